cassette_record: RTL and testbench
==================================

# cassette_record

Cassette recorder for the CoCo3 core: the write-side counterpart of the tape player. It watches the 6-bit sound DAC while the cassette motor relay is on and decodes the CoCo FSK tape signal (2400 Hz = 1, 1200 Hz = 0, LSB first, no start bits). Once aligned on a 0x55 leader byte, it stores each decoded byte sequentially into the cassette SRAM image, so a saved program can later be replayed by the player.

## Interface
Parameters:
- `TICK_DIV`, default 57: clk cycles per timing tick (≈1 µs at 57.27 MHz).
- `HI_TH`, default 36: DAC level at or above which the comparator goes high.
- `LO_TH`, default 28: DAC level at or below which the comparator goes low.
- `MIN_US`, default 200: edge periods shorter than this (ticks) are glitches.
- `SPLIT_US`, default 625: periods below this decode as bit 1, at or above as bit 0.
- `GAP_US`, default 1250: no rising edge for this many ticks is a gap.
- `MAX_ADDR`, default 16'hFFFF: last writable SRAM address.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (clk_sys).
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: cassette motor relay (cas_relay); record only while high.
- `rewind` in 1: clears the image pointer; level-sensitive.
- `dac` in 6: CoCo sound DAC value (cocosound).
- `ram_addr` out 16: SRAM write address.
- `ram_data` out 8: SRAM write data.
- `ram_wr` out 1: one-cycle active-high write strobe.
- `cas_len` out 16: number of bytes recorded.
- `locked` out 1: high while the decoder is byte-aligned.
- `full` out 1: sticky; set when the byte at `MAX_ADDR` has been written.

## Operation
- Input path: `dac` is registered. A hysteresis comparator level `lvl` goes to 1 when the registered value is ≥`HI_TH` and to 0 when it is ≤`LO_TH`; otherwise it holds. A rising edge is a 0→1 change of `lvl`.
- Tick prescaler: counts 0..`TICK_DIV`-1 and emits one tick per wrap. It runs only while `en` is high.
- Period counter: 12 bits, counts ticks, saturates at 4095. It clears on each accepted rising edge.
- States:
  - IDLE: entered on reset or whenever `en` is low; counters are cleared and there is no decoding.
  - ARM: first rising edge after `en` rises, or after a gap. It only starts period measurement, then moves to HUNT.
  - HUNT: bits are decoded and shifted into shift register `sr`. When `sr` equals 8'h55, the state moves to LOCKED and 8'h55 is written.
  - LOCKED: every 8 decoded bits, `sr` is written and the bit count resets.
- Edge classification, applied on a rising edge in HUNT or LOCKED with period P:
  - P < `MIN_US`: edge ignored; the counter keeps running.
  - `MIN_US` ≤ P < `SPLIT_US`: bit 1.
  - `SPLIT_US` ≤ P < `GAP_US`: bit 0.
- Bit shift: a decoded bit enters at bit 7 and the register shifts right (`sr <= {bit, sr[7:1]}`), so the LSB is received first.
- Gap: when the period counter reaches `GAP_US` in HUNT or LOCKED, the state goes to ARM, `sr` and the bit count clear, and a partial byte is discarded.
- Write:
  - `ram_data` = byte and `ram_wr` = 1 for one cycle at address `ram_addr`.
  - On the following cycle, `ram_addr` increments and `cas_len` = `ram_addr`+1.
  - A write at `MAX_ADDR` sets `full` and the address holds.
  - While `full` is set, all later writes are suppressed; decoding continues.
- Rewind:
  - `ram_addr`, `cas_len` and `full` clear.
  - If `en` is high, the state goes to ARM; otherwise it goes to IDLE.
  - Rewind takes priority over a same-cycle write, and that write is dropped.
- `en` falling mid-byte: go to IDLE, discard the partial byte, keep `ram_addr` and `cas_len` (the next save appends).
- `locked` = (state == LOCKED).

## Timing
- Reset values:
  - `ram_addr`=0, `ram_data`=0, `ram_wr`=0, `cas_len`=0, `locked`=0, `full`=0.
  - State IDLE, `lvl`=0.
- Pipeline for a rising edge:
  - clk N: `dac` register captures the crossing value.
  - N+1: `lvl` updates.
  - N+2: edge detected, period classified, bit shifted.
  - N+3: `ram_wr` high if the byte completed.
- Write-path outputs:
  - `ram_addr` and `ram_data` are stable throughout the `ram_wr` cycle.
  - `ram_addr` changes in N+4.
  - Back-to-back writes are at least 8 edges apart, i.e. never on adjacent cycles.
- Period measurement accuracy is ±1 tick. Comparisons use the period value registered at the edge cycle.
- Gap detection fires in the cycle the counter reaches `GAP_US`. A same-cycle rising edge is classified first: if P < `GAP_US` the edge wins.

## Test plan
- Leader then sync: `en`=1; 4×0x55 then 0x3C, square wave on `dac` (0↔63) at 2400/1200 Hz → writes 55,55,55,55,3C at addr 0..4; `cas_len`=5; `locked`=1 after the first 0x55.
- Glitch rejection: 50 µs pulses inserted mid-bit of 0x3C → identical bytes and addresses as the clean run.
- Hysteresis: `dac` oscillating 30↔34 plus a valid 1200 Hz 20↔40 signal → only the 20↔40 edges are counted.
- Gap realign: 0x55, then a 2 ms flat line mid-byte, then 0x55 0xA5 → partial byte dropped; `locked` falls then rises; writes 55,55,A5.
- Full: `MAX_ADDR`=3; send 6 bytes → addr 0..3 written, `full`=1, `cas_len`=4, no further `ram_wr`.
- Rewind/en: `rewind` pulse coinciding with a write cycle → no write, `ram_addr`=0. Dropping `en` mid-byte → IDLE, `cas_len` unchanged; resuming appends at the old address.

Source files
------------

// File: rtl/cassette_record.sv
// cassette_record: write side of the CoCo3 cassette image.
// It listens to the 6-bit sound DAC while the cassette motor relay is on and
// decodes the CoCo FSK tape signal. One full square-wave cycle carries one bit:
// 2400 Hz is a 1 and 1200 Hz is a 0, sent LSB first with no start bits.
// Once it has aligned on a 0x55 leader byte, it writes each decoded byte to
// consecutive addresses of the cassette SRAM image.
//
// Ports:
//   clk       in   1  system clock
//   reset     in   1  synchronous reset, active high
//   en        in   1  cassette motor relay; decoding only runs while high
//   rewind    in   1  level-sensitive clear of the image pointer
//   dac       in   6  CoCo sound DAC value
//   ram_addr  out 16  SRAM write address
//   ram_data  out  8  SRAM write data
//   ram_wr    out  1  single-cycle write strobe
//   cas_len   out 16  number of bytes recorded
//   locked    out  1  decoder is byte-aligned
//   full      out  1  sticky: the byte at MAX_ADDR has been written
module cassette_record #(
  parameter int unsigned TICK_DIV = 57,
  parameter int unsigned HI_TH    = 36,
  parameter int unsigned LO_TH    = 28,
  parameter int unsigned MIN_US   = 200,
  parameter int unsigned SPLIT_US = 625,
  parameter int unsigned GAP_US   = 1250,
  parameter logic [15:0] MAX_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        rewind,
  input  logic [5:0]  dac,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  output logic [15:0] cas_len,
  output logic        locked,
  output logic        full
);

  localparam int unsigned  PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]   HI_LVL   = 6'(HI_TH);
  localparam logic [5:0]   LO_LVL   = 6'(LO_TH);
  localparam logic [11:0]  MIN_P    = 12'(MIN_US);
  localparam logic [11:0]  SPLIT_P  = 12'(SPLIT_US);
  localparam logic [11:0]  GAP_P    = 12'(GAP_US);
  localparam logic [11:0]  PER_MAX  = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HUNT = 2'd2,
    S_LOCK = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    dac_q, dac_d;
  logic          lvl_q, lvl_d;
  logic          lvl_prev_q, lvl_prev_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   per_q, per_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          wr_q, wr_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic          full_q, full_d;
  logic          locked_q, locked_d;

  logic          tick_s;
  logic          edge_s;
  logic          accept_s;
  logic          gap_s;
  logic          bit_s;
  logic [7:0]    shift_s;
  logic [11:0]   per_run_s;
  logic          done_s;

  assign tick_s    = en && (pre_q == PRE_LAST);
  assign edge_s    = lvl_q && !lvl_prev_q;
  // The period is taken from the registered counter at the edge cycle.
  // An edge with P < GAP wins over a gap that fires in the same cycle.
  assign accept_s  = edge_s && (per_q >= MIN_P) && (per_q < GAP_P);
  assign gap_s     = (per_q >= GAP_P);
  assign bit_s     = (per_q < SPLIT_P);
  assign shift_s   = {bit_s, sr_q[7:1]};
  assign per_run_s = (tick_s && (per_q != PER_MAX)) ? (per_q + 12'd1) : per_q;

  // Next-state logic for the input path, timing, decoder FSM and write path
  always_comb begin
    state_d    = state_q;
    dac_d      = dac;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    pre_d      = pre_q;
    per_d      = per_q;
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    len_d      = len_q;
    full_d     = full_q;
    done_s     = 1'b0;

    // Hysteresis comparator: between the thresholds the level holds.
    if (dac_q >= HI_LVL) begin
      lvl_d = 1'b1;
    end else if (dac_q <= LO_LVL) begin
      lvl_d = 1'b0;
    end else begin
      lvl_d = lvl_q;
    end

    if (!en) begin
      pre_d = {PW{1'b0}};
    end else if (pre_q == PRE_LAST) begin
      pre_d = {PW{1'b0}};
    end else begin
      pre_d = pre_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        per_d  = 12'd0;
        sr_d   = 8'h00;
        bcnt_d = 3'd0;
        if (en) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        // The arming edge only starts the measurement; no bit is decoded.
        per_d = 12'd0;
        if (edge_s) begin
          state_d = S_HUNT;
        end else begin
          state_d = S_ARM;
        end
      end
      S_HUNT, S_LOCK: begin
        if (accept_s) begin
          per_d = 12'd0;
          sr_d  = shift_s;
          if (state_q == S_HUNT) begin
            if (shift_s == 8'h55) begin
              state_d = S_LOCK;
              bcnt_d  = 3'd0;
              done_s  = 1'b1;
            end else begin
              state_d = S_HUNT;
            end
          end else begin
            if (bcnt_q == 3'd7) begin
              bcnt_d = 3'd0;
              done_s = 1'b1;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end else if (gap_s) begin
          // The line went quiet: drop any partial byte and wait for a new arming edge.
          state_d = S_ARM;
          per_d   = 12'd0;
          sr_d    = 8'h00;
          bcnt_d  = 3'd0;
        end else begin
          // Either no edge arrived, or a glitch arrived (P < MIN); the counter keeps running.
          per_d = per_run_s;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done_s && !full_q) begin
      wr_d = 1'b1;
    end else begin
      wr_d = 1'b0;
    end

    // The address advances in the cycle after the strobe. At MAX_ADDR it holds and full is set.
    if (wr_q) begin
      len_d = addr_q + 16'd1;
      if (addr_q == MAX_ADDR) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 16'd1;
      end
    end else begin
      len_d = len_q;
    end

    // Motor off: discard the partial byte, keep the pointer so the next save appends.
    if (!en) begin
      state_d = S_IDLE;
      per_d   = 12'd0;
      sr_d    = 8'h00;
      bcnt_d  = 3'd0;
      wr_d    = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Rewind beats everything, including a write being issued this cycle.
    if (rewind) begin
      addr_d  = 16'd0;
      len_d   = 16'd0;
      full_d  = 1'b0;
      wr_d    = 1'b0;
      per_d   = 12'd0;
      sr_d    = 8'h00;
      bcnt_d  = 3'd0;
      state_d = en ? S_ARM : S_IDLE;
    end else begin
      addr_d = addr_d;
    end

    if (wr_d) begin
      data_d = shift_s;
    end else begin
      data_d = data_q;
    end

    locked_d = (state_d == S_LOCK);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dac_q      <= 6'd0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      pre_q      <= {PW{1'b0}};
      per_q      <= 12'd0;
      sr_q       <= 8'h00;
      bcnt_q     <= 3'd0;
      wr_q       <= 1'b0;
      data_q     <= 8'h00;
      addr_q     <= 16'd0;
      len_q      <= 16'd0;
      full_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dac_q      <= dac_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      pre_q      <= pre_d;
      per_q      <= per_d;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      locked_q   <= locked_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_wr   = wr_q;
  assign cas_len  = len_q;
  assign locked   = locked_q;
  assign full     = full_q;

endmodule

// File: tb/tb_cassette_record.sv
// Self-checking bench for cassette_record. To keep the run short it uses
// compressed timing: 2 clocks per tick, MIN=20, SPLIT=60 and GAP=120 ticks,
// and MAX_ADDR=7. The reference model keeps the list of bits that each
// segment delivered. After a gap, a rewind or a motor stop, it searches that
// list for the first 0x55 window, slices the rest into bytes and maps them
// onto image addresses.
module tb_cassette_record;

  localparam logic [15:0] MAXA = 16'd7;

  logic        clk = 1'b0;
  logic        reset, en, rewind;
  logic [5:0]  dac;
  logic [15:0] ram_addr, cas_len;
  logic [7:0]  ram_data;
  logic        ram_wr, locked, full;

  cassette_record #(
    .TICK_DIV(2), .HI_TH(36), .LO_TH(28), .MIN_US(20),
    .SPLIT_US(60), .GAP_US(120), .MAX_ADDR(MAXA)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rewind(rewind), .dac(dac),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
    .cas_len(cas_len), .locked(locked), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          seg_bits[$];
  int          seg_armed = 0;
  int          pend_valid = 0;
  int          pend_bit = 0;
  logic [15:0] m_addr = 16'd0;
  logic [15:0] m_len = 16'd0;
  int          m_full = 0;
  logic        prev_wr = 1'b0;

  typedef struct {
    int          n_lead;
    logic [7:0]  payload;
    int          style;
    logic [15:0] exp_len;
    logic        exp_locked;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record every write strobe; check it is isolated and issued while locked
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      got_q.push_back({ram_addr, ram_data});
      check("wr_not_adjacent", {31'd0, prev_wr}, 32'd0);
      check("locked_at_write", {31'd0, locked}, 32'd1);
    end
    prev_wr = ram_wr;
  end

  // ---------------- reference model ----------------
  task automatic model_write(input logic [7:0] b);
    if (m_full == 0) begin
      exp_q.push_back({m_addr, b});
      m_len = m_addr + 16'd1;
      if (m_addr == MAXA) m_full = 1;
      else m_addr = m_addr + 16'd1;
    end
  endtask

  task automatic seg_reset();
    seg_bits.delete();
    seg_armed = 0;
    pend_valid = 0;
  endtask

  task automatic model_flush();
    int start;
    int v;
    start = -1;
    for (int i = 7; i < seg_bits.size(); i++) begin
      v = 0;
      for (int j = 0; j < 8; j++) v += seg_bits[i-7+j] << j;
      if (v == 'h55) begin
        start = i;
        break;
      end
    end
    if (start >= 0) begin
      model_write(8'h55);
      for (int p = start + 1; p + 7 < seg_bits.size(); p += 8) begin
        v = 0;
        for (int j = 0; j < 8; j++) v += seg_bits[p+j] << j;
        model_write(v[7:0]);
      end
    end
    seg_reset();
  endtask

  // A rising edge closes the pending bit; the first edge of a segment only arms.
  task automatic model_edge(input int has_bit, input int b);
    if (seg_armed == 0) seg_armed = 1;
    else if (pend_valid != 0) seg_bits.push_back(pend_bit);
    pend_valid = has_bit;
    pend_bit = b;
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [5:0] level_for(input int style, input int i, input int high);
    logic [5:0] v;
    if (style == 2) begin
      v = (high != 0) ? 6'd40 : 6'd20;
      if (i % 4 == 1) v = 6'd34;
      else if (i % 4 == 2) v = 6'd30;
    end else if (style == 1) begin
      v = (high != 0 && !(i >= 3 && i < 6)) ? 6'd63 : 6'd0;
    end else begin
      v = (high != 0) ? 6'd63 : 6'd0;
    end
    return v;
  endfunction

  task automatic send_bit(input int b, input int style);
    int half;
    half = (b != 0) ? int'($urandom_range(50, 30)) : int'($urandom_range(100, 70));
    model_edge(1, b);
    for (int i = 0; i < half; i++) begin dac = level_for(style, i, 1); @(negedge clk); end
    for (int i = 0; i < half; i++) begin dac = level_for(style, i, 0); @(negedge clk); end
  endtask

  task automatic send_byte(input logic [7:0] b, input int style);
    for (int j = 0; j < 8; j++) send_bit(int'(b[j]), style);
  endtask

  task automatic close_edge();
    model_edge(0, 0);
    dac = 6'd63;
    repeat (20) @(negedge clk);
    dac = 6'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle_gap();
    dac = 6'd0;
    repeat (300) @(negedge clk);
    model_flush();
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    m_addr = 16'd0;
    m_len = 16'd0;
    m_full = 0;
    seg_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_write"}, {8'd0, got_q[i]}, {8'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n_lead: 4, payload: 8'h3C, style: 0, exp_len: 16'd5, exp_locked: 1'b1};
    tbl[1] = '{n_lead: 2, payload: 8'h3C, style: 1, exp_len: 16'd3, exp_locked: 1'b1};
    tbl[2] = '{n_lead: 1, payload: 8'hA7, style: 2, exp_len: 16'd2, exp_locked: 1'b1};
    tbl[3] = '{n_lead: 3, payload: 8'h00, style: 0, exp_len: 16'd4, exp_locked: 1'b1};

    reset = 1'b1; en = 1'b0; rewind = 1'b0; dac = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_data", ram_data, 32'd0);
    check("rst_wr", ram_wr, 32'd0);
    check("rst_len", cas_len, 32'd0);
    check("rst_locked", locked, 32'd0);
    check("rst_full", full, 32'd0);
    reset = 1'b0;
    en = 1'b1;
    repeat (10) @(negedge clk);

    // Table: leader plus payload, clean, glitched and noisy hysteresis
    for (int t = 0; t < 4; t++) begin
      do_rewind();
      for (int k = 0; k < tbl[t].n_lead; k++) send_byte(8'h55, tbl[t].style);
      send_byte(tbl[t].payload, tbl[t].style);
      close_edge();
      check("tbl_len", cas_len, tbl[t].exp_len);
      check("tbl_locked", locked, tbl[t].exp_locked);
      check("tbl_full", full, 32'd0);
      idle_gap();
      check("tbl_gap_unlock", locked, 32'd0);
      compare_writes("tbl");
    end

    // Gap realign: the partial byte is dropped and lock is reacquired
    do_rewind();
    send_byte(8'h55, 0);
    for (int j = 0; j < 4; j++) send_bit(j % 2, 0);
    check("gap_locked_before", locked, 32'd1);
    idle_gap();
    check("gap_locked_after", locked, 32'd0);
    send_byte(8'h55, 0);
    send_byte(8'hA5, 0);
    close_edge();
    check("gap_relock", locked, 32'd1);
    idle_gap();
    check("gap_len", cas_len, 32'd3);
    compare_writes("gap");

    // Full: 10 bytes into an 8-byte image
    do_rewind();
    send_byte(8'h55, 0);
    for (int k = 0; k < 9; k++) send_byte(8'($urandom), 0);
    close_edge();
    check("full_flag", full, 32'd1);
    check("full_len", cas_len, 32'd8);
    check("full_addr", ram_addr, 32'd7);
    idle_gap();
    compare_writes("full");

    // Rewind lands on the cycle that would issue the write
    do_rewind();
    send_byte(8'h55, 0);
    dac = 6'd63;
    repeat (2) @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    m_addr = 16'd0; m_len = 16'd0; m_full = 0;
    seg_reset();
    repeat (20) @(negedge clk);
    dac = 6'd0;
    repeat (20) @(negedge clk);
    check("rw_addr", ram_addr, 32'd0);
    check("rw_len", cas_len, 32'd0);
    check("rw_locked", locked, 32'd0);
    idle_gap();
    compare_writes("rw");

    // Motor drops mid-byte, then resumes and appends
    do_rewind();
    send_byte(8'h55, 0);
    for (int j = 0; j < 4; j++) send_bit(1, 0);
    en = 1'b0;
    seg_bits.push_back(0);
    void'(seg_bits.pop_back());
    pend_valid = 0;
    model_flush();
    repeat (5) @(negedge clk);
    check("en_len", cas_len, 32'd1);
    check("en_locked", locked, 32'd0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h55, 0);
    send_byte(8'h12, 0);
    close_edge();
    idle_gap();
    check("en_append_len", cas_len, 32'd3);
    compare_writes("en");

    // Random: junk prefix bits, a leader, then random payload
    for (int it = 0; it < 4; it++) begin
      int npre;
      int nb;
      do_rewind();
      npre = int'($urandom_range(6, 0));
      for (int j = 0; j < npre; j++) send_bit(int'($urandom_range(1, 0)), 0);
      send_byte(8'h55, 0);
      nb = int'($urandom_range(3, 1));
      for (int k = 0; k < nb; k++) send_byte(8'($urandom), 0);
      close_edge();
      check("rnd_locked", locked, 32'd1);
      idle_gap();
      check("rnd_len", cas_len, {16'd0, m_len});
      compare_writes("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
